// File: rtl/conv_tile_mac_engine.sv
// conv_tile_mac_engine
// Fixed-point convolution tile engine: accumulates K*K*C weighted operand tiles
// into PARA_X*PARA_Y accumulators, then shifts, saturates and optionally applies
// ReLU before presenting the result tile.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start, abort        tile launch (IDLE only) / discard current tile
//   kernel_size         K, legal 1..KS_MAX
//   in_channels         C, legal 1..2^CH_WIDTH-1
//   out_shift, relu_en  post-accumulation arithmetic shift / negative clamp
//   in_valid/in_ready   operand beat handshake (in_data tile + shared weight)
//   tap_row/col/ch      kernel position of the next expected beat
//   out_valid/out_ready result tile handshake (out_data)
//   busy                engine not idle
//   cfg_err             one-cycle pulse on start with illegal K or C
module conv_tile_mac_engine #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH   = 40,
  parameter int unsigned PARA_X      = 3,
  parameter int unsigned PARA_Y      = 3,
  parameter int unsigned KS_MAX      = 7,
  parameter int unsigned KS_WIDTH    = 3,
  parameter int unsigned CH_WIDTH    = 8,
  parameter int unsigned SHIFT_WIDTH = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [KS_WIDTH-1:0]                  kernel_size,
  input  logic [CH_WIDTH-1:0]                  in_channels,
  input  logic [SHIFT_WIDTH-1:0]               out_shift,
  input  logic                                 relu_en,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]  in_data,
  input  logic [DATA_WIDTH-1:0]                weight,
  output logic [KS_WIDTH-1:0]                  tap_row,
  output logic [KS_WIDTH-1:0]                  tap_col,
  output logic [CH_WIDTH-1:0]                  tap_ch,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]  out_data,
  output logic                                 busy,
  output logic                                 cfg_err
);

  localparam int unsigned N  = PARA_X * PARA_Y;
  localparam int unsigned PW = 2 * DATA_WIDTH;

  localparam logic [KS_WIDTH:0]                KS_LIM  = (KS_WIDTH + 1)'(KS_MAX);
  localparam logic signed [ACC_WIDTH-1:0]      SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0]      SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  logic [KS_WIDTH-1:0]    k_q;
  logic [CH_WIDTH-1:0]    c_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic                   relu_q;

  logic signed [ACC_WIDTH-1:0] acc_q   [N];
  logic signed [ACC_WIDTH-1:0] acc_nxt [N];
  logic signed [PW-1:0]        prod_c  [N];

  logic                cfg_ok_c, accept_c, first_c, last_c;
  logic                col_last_c, row_last_c, ch_last_c;
  logic [KS_WIDTH-1:0] col_nxt, row_nxt;
  logic [CH_WIDTH-1:0] ch_nxt;

  // Shift, saturate to DATA_WIDTH, then optional ReLU clamp.
  function automatic logic [DATA_WIDTH-1:0] sat_relu(
    input logic signed [ACC_WIDTH-1:0] v,
    input logic [SHIFT_WIDTH-1:0]      sh,
    input logic                        relu
  );
    logic signed [ACC_WIDTH-1:0] s;
    s = v >>> sh;
    if (relu && s[ACC_WIDTH-1])
      s = '0;
    else if (s > SAT_MAX)
      s = SAT_MAX;
    else if (s < SAT_MIN)
      s = SAT_MIN;
    return DATA_WIDTH'(s);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_nxt;
  end

  // Next-state and beat acceptance.
  always_comb begin
    state_nxt = state_q;
    accept_c  = 1'b0;
    cfg_ok_c  = (kernel_size != '0) && ({1'b0, kernel_size} <= KS_LIM) && (in_channels != '0);
    unique case (state_q)
      S_IDLE: if (start && cfg_ok_c) state_nxt = S_MAC;
      S_MAC: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          accept_c = in_valid && in_ready;
          if (accept_c && last_c) state_nxt = S_OUT;
        end
      end
      S_OUT:   if (abort || out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tap counters: column fastest, then row, then channel.
  always_comb begin
    col_last_c = (tap_col == (k_q - KS_WIDTH'(1)));
    row_last_c = (tap_row == (k_q - KS_WIDTH'(1)));
    ch_last_c  = (tap_ch  == (c_q - CH_WIDTH'(1)));
    last_c     = col_last_c && row_last_c && ch_last_c;
    first_c    = (tap_col == '0) && (tap_row == '0) && (tap_ch == '0);
    col_nxt    = tap_col + KS_WIDTH'(1);
    row_nxt    = tap_row;
    ch_nxt     = tap_ch;
    if (col_last_c) begin
      col_nxt = '0;
      row_nxt = tap_row + KS_WIDTH'(1);
      if (row_last_c) begin
        row_nxt = '0;
        ch_nxt  = ch_last_c ? '0 : tap_ch + CH_WIDTH'(1);
      end
    end
  end

  // Per-element product; the first beat of a tile overwrites stale accumulators.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      prod_c[i]  = PW'(signed'(in_data[i*DATA_WIDTH +: DATA_WIDTH])) * PW'(signed'(weight));
      acc_nxt[i] = first_c ? ACC_WIDTH'(prod_c[i]) : acc_q[i] + ACC_WIDTH'(prod_c[i]);
    end
  end

  // Datapath, configuration latch and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
      out_data  <= '0;
      tap_row   <= '0;
      tap_col   <= '0;
      tap_ch    <= '0;
      k_q       <= '0;
      c_q       <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      for (int unsigned i = 0; i < N; i++) acc_q[i] <= '0;
    end else begin
      in_ready  <= (state_nxt == S_MAC);
      out_valid <= (state_nxt == S_OUT);
      busy      <= (state_nxt != S_IDLE);
      cfg_err   <= (state_q == S_IDLE) && start && !cfg_ok_c;
      if ((state_q == S_IDLE) && start && cfg_ok_c) begin
        k_q     <= kernel_size;
        c_q     <= in_channels;
        shift_q <= out_shift;
        relu_q  <= relu_en;
        tap_row <= '0;
        tap_col <= '0;
        tap_ch  <= '0;
      end else if (abort && (state_q != S_IDLE)) begin
        tap_row <= '0;
        tap_col <= '0;
        tap_ch  <= '0;
      end else if (accept_c) begin
        tap_row <= row_nxt;
        tap_col <= col_nxt;
        tap_ch  <= ch_nxt;
        for (int unsigned i = 0; i < N; i++) acc_q[i] <= acc_nxt[i];
        if (last_c) begin
          for (int unsigned i = 0; i < N; i++)
            out_data[i*DATA_WIDTH +: DATA_WIDTH] <= sat_relu(acc_nxt[i], shift_q, relu_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_tile_mac_engine.sv
// Self-checking bench for conv_tile_mac_engine: randomized and directed tiles
// compared against a sum-of-products reference model.
module tb_conv_tile_mac_engine;

  localparam int DW = 16;
  localparam int N  = 9;
  localparam int TW = N * DW;
  localparam int KW = 3;
  localparam int CW = 8;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [KW-1:0] kernel_size = '0;
  logic [CW-1:0] in_channels = '0;
  logic [SW-1:0] out_shift = '0;
  logic          relu_en = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_data = '0;
  logic [DW-1:0] weight = '0;
  logic [KW-1:0] tap_row;
  logic [KW-1:0] tap_col;
  logic [CW-1:0] tap_ch;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [TW-1:0] out_data;
  logic          busy;
  logic          cfg_err;

  int total = 0;
  int bad   = 0;

  logic [TW-1:0] beat_data [$];
  logic [DW-1:0] beat_w    [$];

  conv_tile_mac_engine dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .kernel_size(kernel_size), .in_channels(in_channels),
    .out_shift(out_shift), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .weight(weight),
    .tap_row(tap_row), .tap_col(tap_col), .tap_ch(tap_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TW-1:0] rnd_tile();
    logic [TW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Reference: plain sum of products over all beats, 40-bit wrap, shift, clamp.
  function automatic logic [TW-1:0] model(input int sh, input bit relu);
    logic [TW-1:0] r;
    longint s;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] w;
    r = '0;
    for (int i = 0; i < N; i++) begin
      s = 0;
      for (int b = 0; b < beat_data.size(); b++) begin
        a = beat_data[b][i*DW +: DW];
        w = beat_w[b];
        s += longint'(a) * longint'(w);
      end
      s = (s <<< 24) >>> 24;
      s = s >>> sh;
      if (relu && s < 0) s = 0;
      else if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      r[i*DW +: DW] = DW'(s);
    end
    return r;
  endfunction

  task automatic fill_random(input int n);
    beat_data.delete();
    beat_w.delete();
    for (int b = 0; b < n; b++) begin
      beat_data.push_back(rnd_tile());
      beat_w.push_back(DW'($urandom));
    end
  endtask

  task automatic fill_const(input int n, input logic [DW-1:0] op, input logic [DW-1:0] w);
    beat_data.delete();
    beat_w.delete();
    for (int b = 0; b < n; b++) begin
      beat_data.push_back({N{op}});
      beat_w.push_back(w);
    end
  endtask

  task automatic run_tile(input int k, input int c, input int sh, input bit relu,
                          input int gap_pct, input int hold, input bit start_at_ack,
                          output logic [TW-1:0] got);
    logic [TW-1:0] exp_t;
    int n;
    int gaps;
    exp_t = model(sh, relu);
    n = k * k * c;
    if (n != beat_data.size()) begin
      $display("FAIL tile_setup beats=%0d need=%0d", beat_data.size(), n);
      $fatal(1, "bench setup error");
    end
    kernel_size = KW'(k); in_channels = CW'(c); out_shift = SW'(sh); relu_en = relu;
    start = 1'b1;
    step;
    start = 1'b0;
    // Config changes during the tile must not matter.
    kernel_size = KW'($urandom); in_channels = CW'($urandom);
    out_shift = SW'($urandom); relu_en = ~relu;
    total++;
    if ({busy, in_ready, out_valid, cfg_err} !== 4'b1100) begin
      bad++;
      $display("FAIL start_state got=%b want=1100", {busy, in_ready, out_valid, cfg_err});
    end
    for (int b = 0; b < n; b++) begin
      gaps = 0;
      while (gaps < 3 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = rnd_tile();
        weight   = DW'($urandom);
        step;
        gaps++;
      end
      in_valid = 1'b1;
      in_data  = beat_data[b];
      weight   = beat_w[b];
      total++;
      if ({tap_ch, tap_row, tap_col, in_ready, out_valid} !==
          {CW'(b / (k * k)), KW'((b / k) % k), KW'(b % k), 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL beat_taps b=%0d got ch=%0d row=%0d col=%0d rdy=%b ov=%b want ch=%0d row=%0d col=%0d rdy=1 ov=0",
                 b, tap_ch, tap_row, tap_col, in_ready, out_valid, b / (k * k), (b / k) % k, b % k);
      end
      step;
    end
    in_valid = 1'b0;
    total++;
    if ({out_valid, in_ready, busy} !== 3'b101) begin
      bad++;
      $display("FAIL out_latency got ov/rdy/busy=%b want=101", {out_valid, in_ready, busy});
    end
    total++;
    if (out_data !== exp_t) begin
      bad++;
      $display("FAIL out_data got=%h want=%h", out_data, exp_t);
    end
    for (int h = 0; h < hold; h++) begin
      step;
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_t) begin
        bad++;
        $display("FAIL out_hold cyc=%0d got ov=%b data=%h want ov=1 data=%h", h, out_valid, out_data, exp_t);
      end
    end
    got = out_data;
    out_ready = 1'b1;
    if (start_at_ack) begin
      kernel_size = KW'(k); in_channels = CW'(c); start = 1'b1;
    end
    step;
    out_ready = 1'b0;
    start = 1'b0;
    total++;
    if ({busy, out_valid, in_ready} !== 3'b000) begin
      bad++;
      $display("FAIL ack_idle got busy/ov/rdy=%b want=000", {busy, out_valid, in_ready});
    end
    step;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_on_ack got busy=%b want=0", busy);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, busy, cfg_err, out_data, tap_row, tap_col, tap_ch} !== '0) begin
      bad++;
      $display("FAIL reset got rdy=%b ov=%b busy=%b err=%b data=%h taps=%0d/%0d/%0d want all 0",
               in_ready, out_valid, busy, cfg_err, out_data, tap_row, tap_col, tap_ch);
    end
    rst = 1'b1;
    step;
  endtask

  task automatic test_basic;
    logic [TW-1:0] got;
    beat_data.delete();
    beat_w.delete();
    for (int b = 0; b < 9; b++) begin
      beat_data.push_back({N{16'h0001}});
      beat_w.push_back(DW'(b + 1));
    end
    run_tile(3, 1, 0, 1'b0, 0, 0, 1'b1, got);
    total++;
    if (got !== {N{16'd45}}) begin
      bad++;
      $display("FAIL basic_45 got=%h want=%h", got, {N{16'd45}});
    end
  endtask

  task automatic test_random_gaps;
    logic [TW-1:0] got;
    fill_random(50);
    run_tile(5, 2, 10, 1'b0, 30, 0, 1'b0, got);
    fill_random(12);
    run_tile(2, 3, 0, 1'b1, 40, 2, 1'b0, got);
  endtask

  task automatic test_saturation;
    logic [TW-1:0] got;
    fill_const(9, 16'h7FFF, 16'h7FFF);
    run_tile(3, 1, 0, 1'b0, 0, 0, 1'b0, got);
    total++;
    if (got !== {N{16'h7FFF}}) begin
      bad++;
      $display("FAIL sat_pos got=%h want=%h", got, {N{16'h7FFF}});
    end
    fill_const(9, 16'h7FFF, 16'h8001);
    run_tile(3, 1, 0, 1'b0, 0, 0, 1'b0, got);
    total++;
    if (got !== {N{16'h8000}}) begin
      bad++;
      $display("FAIL sat_neg got=%h want=%h", got, {N{16'h8000}});
    end
    run_tile(3, 1, 0, 1'b1, 0, 0, 1'b0, got);
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL relu got=%h want=0", got);
    end
  endtask

  task automatic test_shift_hold;
    logic [TW-1:0] got;
    fill_const(1, 16'hFFF6, 16'd10);
    run_tile(1, 1, 4, 1'b0, 0, 10, 1'b0, got);
    total++;
    if (got !== {N{16'hFFF9}}) begin
      bad++;
      $display("FAIL shift_floor got=%h want=%h", got, {N{16'hFFF9}});
    end
  endtask

  task automatic cfg_bad(input int k, input int c);
    kernel_size = KW'(k);
    in_channels = CW'(c);
    start = 1'b1;
    step;
    start = 1'b0;
    total++;
    if ({cfg_err, busy, in_ready} !== 3'b100) begin
      bad++;
      $display("FAIL cfg_err_pulse k=%0d c=%0d got err/busy/rdy=%b want=100", k, c, {cfg_err, busy, in_ready});
    end
    step;
    total++;
    if ({cfg_err, busy} !== 2'b00) begin
      bad++;
      $display("FAIL cfg_err_clear k=%0d c=%0d got err/busy=%b want=00", k, c, {cfg_err, busy});
    end
  endtask

  task automatic test_cfg;
    logic [TW-1:0] got;
    cfg_bad(0, 1);
    cfg_bad(8, 1);
    cfg_bad(3, 0);
    fill_random(49);
    run_tile(7, 1, 12, 1'b0, 10, 0, 1'b0, got);
  endtask

  task automatic test_abort;
    logic [TW-1:0] got;
    kernel_size = 3'd3; in_channels = 8'd1; out_shift = '0; relu_en = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1;
      in_data  = rnd_tile();
      weight   = DW'($urandom);
      step;
    end
    in_data = rnd_tile();
    abort = 1'b1;
    step;
    abort = 1'b0;
    in_valid = 1'b0;
    total++;
    if ({busy, in_ready, out_valid} !== 3'b000) begin
      bad++;
      $display("FAIL abort_idle got busy/rdy/ov=%b want=000", {busy, in_ready, out_valid});
    end
    fill_random(9);
    run_tile(3, 1, 3, 1'b0, 20, 0, 1'b0, got);
  endtask

  task automatic test_reset_mid;
    logic [TW-1:0] got;
    kernel_size = 3'd3; in_channels = 8'd2; out_shift = '0; relu_en = 1'b0;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      in_valid = 1'b1;
      in_data  = rnd_tile();
      weight   = DW'($urandom);
      step;
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, busy, cfg_err, out_data, tap_row, tap_col, tap_ch} !== '0) begin
      bad++;
      $display("FAIL reset_mid got rdy=%b ov=%b busy=%b err=%b data=%h taps=%0d/%0d/%0d want all 0",
               in_ready, out_valid, busy, cfg_err, out_data, tap_row, tap_col, tap_ch);
    end
    step;
    rst = 1'b1;
    step;
    fill_random(12);
    run_tile(2, 3, 1, 1'b0, 0, 0, 1'b0, got);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_random_gaps;
    test_saturation;
    test_shift_hold;
    test_cfg;
    test_abort;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
